chip8_draw_engine: RTL

CHIP8_DRAW_ENGINE -- requirements
Module: chip8_draw_engine

---
 rtl/chip8_draw_engine.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/chip8_draw_engine.sv
// ---------------------------------------------------------------------------
// chip8_draw_engine
//
// Purpose: CHIP-8 display coprocessor. It executes the 00E0 command (clear
// screen) and the DXYN command (XOR-draw an 8-pixel-wide sprite) into a
// 64x32 monochrome framebuffer held in flops. It also produces the VF
// collision flag.
//
// Ports:
//   SYS_CLK     system clock, all state updates on the rising edge
//   CPU_RESETN  synchronous active-low reset
//   start       one-cycle command strobe, sampled only while idle
//   op_clear    qualifies start: 1 = clear screen, 0 = sprite draw
//   x, y, n     sprite column origin, row origin and height in rows
//   i_addr      sprite base address (I register)
//   mem_rd      one-cycle read request to main memory
//   mem_addr    read address, valid while mem_rd is high
//   mem_data    read data, bit 7 = leftmost pixel
//   mem_valid   read data valid strobe, 1 or more cycles after mem_rd
//   busy        high whenever an operation is in progress
//   done        one-cycle completion pulse
//   collision   VF result, held from done until the next accepted start
//   vidclear    high while the screen is being cleared
//   vidout      framebuffer, pixel (row r, col c) at index r*64+c
//
// Configuration macro: DRAW_CLIP_EN
//   undefined - sprite pixels wrap around the screen edges
//   defined   - sprite pixels beyond column 63 or row 31 are discarded
//               (no write, no collision); off-screen rows are still fetched
//               so the command timing does not change
// ---------------------------------------------------------------------------
module chip8_draw_engine (
    input  logic          SYS_CLK,
    input  logic          CPU_RESETN,
    input  logic          start,
    input  logic          op_clear,
    input  logic [5:0]    x,
    input  logic [4:0]    y,
    input  logic [3:0]    n,
    input  logic [11:0]   i_addr,
    output logic          mem_rd,
    output logic [11:0]   mem_addr,
    input  logic [7:0]    mem_data,
    input  logic          mem_valid,
    output logic          busy,
    output logic          done,
    output logic          collision,
    output logic          vidclear,
    output logic [0:2047] vidout
);

`ifdef DRAW_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT,
        S_DRAW,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      x_q, x_d;
    logic [4:0]      y_q, y_d;
    logic [3:0]      n_q, n_d;
    logic [11:0]     addr_q, addr_d;
    // Row counter is shared: sprite row during a draw, screen row during a clear.
    logic [4:0]      row_q, row_d;
    logic [7:0]      data_q, data_d;
    logic            coll_q, coll_d;
    logic [0:2047]   vid_q, vid_d;

    // Scratch values for the per-pixel draw loop.
    logic [6:0]      col_sum;
    logic [5:0]      row_sum;
    logic [10:0]     pix_idx;
    logic            in_range;

    always_ff @(posedge SYS_CLK) begin
        if (!CPU_RESETN) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            row_q   <= '0;
            data_q  <= '0;
            coll_q  <= 1'b0;
            vid_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            data_q  <= data_d;
            coll_q  <= coll_d;
            vid_q   <= vid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        n_d      = n_q;
        addr_d   = addr_q;
        row_d    = row_q;
        data_d   = data_q;
        coll_d   = coll_q;
        vid_d    = vid_q;
        col_sum  = '0;
        row_sum  = '0;
        pix_idx  = '0;
        in_range = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d    = x;
                    y_d    = y;
                    n_d    = n;
                    addr_d = i_addr;
                    row_d  = '0;
                    coll_d = 1'b0;
                    if (op_clear) begin
                        state_d = S_CLEAR;
                    end else if (n == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_CLEAR: begin
                vid_d[{row_q, 6'd0} +: 64] = '0;
                row_d = row_q + 5'd1;
                if (row_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end

            S_FETCH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (mem_valid) begin
                    data_d  = mem_data;
                    state_d = S_DRAW;
                end
            end

            S_DRAW: begin
                // The 8 target columns are distinct modulo 64, so every pixel
                // can be toggled against the old framebuffer in the same cycle.
                for (int k = 0; k < 8; k++) begin
                    col_sum  = {1'b0, x_q} + 7'(k);
                    row_sum  = {1'b0, y_q} + {1'b0, row_q};
                    pix_idx  = {row_sum[4:0], col_sum[5:0]};
                    in_range = !CLIP_EN || (!col_sum[6] && !row_sum[5]);
                    if (data_q[3'(7 - k)] && in_range) begin
                        if (vid_q[pix_idx]) begin
                            coll_d = 1'b1;
                        end
                        vid_d[pix_idx] = ~vid_q[pix_idx];
                    end
                end
                row_d = row_q + 5'd1;
                if ((row_q + 5'd1) == {1'b0, n_q}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_rd    = (state_q == S_FETCH);
    assign mem_addr  = addr_q + {7'd0, row_q};
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign vidclear  = (state_q == S_CLEAR);
    assign collision = coll_q;
    assign vidout    = vid_q;

endmodule
